// File: rtl/average_arbiter.sv
// average_arbiter
//   Shares one accumulate-and-shift averager between NUM_CH sample requesters.
//   Requesters are granted one at a time in round-robin order. Exactly N
//   samples are taken from the granted channel, and their floor average is
//   emitted with a one-cycle strobe that is tagged with the channel index.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   req       per-channel request, held high for the whole transaction
//   valid_in  data_in carries a sample from the granted channel
//   data_in   sample value
//   grant     one-hot grant, all zero when no channel is granted
//   ready     a sample is accepted this cycle when valid_in is also high
//   avg_out   floor(sum of N samples / N), held until the next completion
//   avg_valid one-cycle strobe qualifying avg_out and avg_ch
//   avg_ch    channel that produced avg_out
//   busy      high while accumulating and during the completion cycle
module average_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int N          = 4096,
  parameter  int NUM_CH     = 3,
  localparam int BITS       = $clog2(N),
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]     grant,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic                  avg_valid,
  output logic [CH_W-1:0]       avg_ch,
  output logic                  busy
);

  localparam int SUM_W = DATA_WIDTH + BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [SUM_W-1:0]  sum;
  logic [BITS-1:0]   count;
  logic [CH_W-1:0]   last_ch;

  logic [CH_W-1:0]   sel;
  logic              found;
  logic              accept;
  logic              last_sample;
  logic [SUM_W-1:0]  sum_next;

  // Round-robin search: channels above last_ch first, then wrap around to
  // channel 0 up to and including last_ch itself.
  always_comb begin
    sel   = last_ch;
    found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && (c > int'(last_ch)) && req[c]) begin
        found = 1'b1;
        sel   = CH_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && (c <= int'(last_ch)) && req[c]) begin
        found = 1'b1;
        sel   = CH_W'(c);
      end
    end
  end

  assign accept      = valid_in && ready;
  assign last_sample = accept && (count == BITS'(N - 1));
  // The final sample is folded in directly so the average is available the
  // cycle after it is accepted.
  assign sum_next    = sum + SUM_W'(data_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      ready     <= 1'b0;
      avg_valid <= 1'b0;
      avg_out   <= '0;
      avg_ch    <= '0;
      busy      <= 1'b0;
      sum       <= '0;
      count     <= '0;
      last_ch   <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          avg_valid <= 1'b0;
          if (found) begin
            state   <= ACCUM;
            grant   <= NUM_CH'(1) << sel;
            ready   <= 1'b1;
            busy    <= 1'b1;
            sum     <= '0;
            count   <= '0;
            last_ch <= sel;
          end
        end

        ACCUM: begin
          // Completion takes priority over a request dropped in the same cycle.
          if (last_sample) begin
            state     <= DONE;
            avg_out   <= DATA_WIDTH'(sum_next >> BITS);
            avg_ch    <= last_ch;
            avg_valid <= 1'b1;
            grant     <= '0;
            ready     <= 1'b0;
          end else if (!req[last_ch]) begin
            // Abort: last_ch keeps the aborted channel so the pointer advances.
            state <= IDLE;
            grant <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            sum   <= '0;
            count <= '0;
          end else if (accept) begin
            sum   <= sum_next;
            count <= count + BITS'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          avg_valid <= 1'b0;
          busy      <= 1'b0;
          sum       <= '0;
          count     <= '0;
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
